// File: rtl/steer_pkg.sv
// Shared definitions for the line-following steering controller.
// Holds the FSM state encoding seen on the state output, the duty ceiling,
// the signed widths of the PD datapath and a saturating duty helper.
package steer_pkg;

  // STOP is not listed here: it is reported as IDLE with an internal stop flag
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_HOLD   = 2'd2,
    ST_SEARCH = 2'd3
  } state_e;

  localparam int DUTY_MAX = 255;

  // error = centroid - setpoint, delta = error - prev_error
  localparam int ERR_W   = 12;
  localparam int DELTA_W = 13;
  // Sum of a shifted 12-bit and a shifted 13-bit signed term
  localparam int CORR_W  = 14;
  // Base speed plus/minus the correction, before clamping
  localparam int SUM_W   = 16;

  // Saturate a signed wheel command into the 0..DUTY_MAX duty range
  function automatic logic [7:0] clamp_duty(input logic signed [SUM_W-1:0] v);
    if (v < 0) begin
      return 8'd0;
    end else if (v > DUTY_MAX) begin
      return 8'hFF;
    end else begin
      return v[7:0];
    end
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// Single-wheel PWM generator.
// A prescaler divides clk by PWM_DIV to advance a free-running 8-bit counter.
// The duty is copied into a shadow register only when the counter wraps
// 255->0, so a period is never cut short by a duty change.
// Ports:
//   clk, rst  - system clock, asynchronous active-high reset
//   duty_i    - requested duty 0..255
//   pwm_o     - high while counter < shadow duty
module pwm_gen #(
  parameter int PWM_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] duty_i,
  output logic       pwm_o
);

  localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  logic [PRE_W-1:0] pre_q;
  logic [7:0]       cnt_q;
  logic [7:0]       shadow_q;
  logic             tick;

  assign tick = (pre_q == PRE_W'(PWM_DIV - 1));

  // Prescaler, counter and shadow reload; the reload happens on the same tick
  // that takes the counter from 255 back to 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q    <= '0;
      cnt_q    <= 8'd0;
      shadow_q <= 8'd0;
    end else if (tick) begin
      pre_q <= '0;
      cnt_q <= cnt_q + 8'd1;
      if (cnt_q == 8'd255) begin
        shadow_q <= duty_i;
      end
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  // Decoded straight from reset-cleared registers, so reset forces it low at once
  assign pwm_o = (cnt_q < shadow_q);

endmodule

// File: rtl/steer_ctrl.sv
// PD steering controller for a two-wheel line follower.
// Stage 1 registers the update event and computes the PD correction from the
// centroid; stage 2 runs the mode FSM and registers the wheel duties, so a
// TRACK update shows up two cycles after its line_valid pulse.
// Ports:
//   clk, rst                  - system clock, asynchronous active-high reset
//   enable_i                  - 0 forces IDLE with motors off
//   centroid_x_i              - line centroid, sampled with line_valid_i
//   line_valid_i/line_lost_i  - update pulses (both high counts as lost)
//   duty_left_o/duty_right_o  - registered duty commands
//   cmd_valid_o               - pulse when the duties change source
//   pwm_left_o/pwm_right_o    - motor PWM outputs
//   state_o                   - IDLE/TRACK/HOLD/SEARCH (STOP reads as IDLE)
module steer_ctrl
  import steer_pkg::*;
#(
  parameter int IMG_W        = 640,
  parameter int KP_SHIFT     = 2,
  parameter int KD_SHIFT     = 3,
  parameter int BASE_SPEED   = 128,
  parameter int SEARCH_SPEED = 96,
  parameter int LOST_HOLD    = 8,
  parameter int LOST_STOP    = 64,
  parameter int PWM_DIV      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic [10:0] centroid_x_i,
  input  logic        line_valid_i,
  input  logic        line_lost_i,
  output logic [7:0]  duty_left_o,
  output logic [7:0]  duty_right_o,
  output logic        cmd_valid_o,
  output logic        pwm_left_o,
  output logic        pwm_right_o,
  output logic [1:0]  state_o
);

  localparam int SETPOINT = IMG_W / 2;
  localparam int LCNT_W   = $clog2(LOST_STOP + 1);

  logic                      valid_ev, lost_ev;
  logic signed [ERR_W-1:0]   err_d;
  logic signed [DELTA_W-1:0] delta_d;
  logic signed [CORR_W-1:0]  p_term_d, d_term_d, corr_d;

  logic                      ev_valid_q, ev_lost_q;
  logic signed [CORR_W-1:0]  corr_q;
  logic signed [ERR_W-1:0]   prev_err_q;
  logic                      have_prev_q;

  logic signed [SUM_W-1:0]   sum_l_d, sum_r_d;
  logic [LCNT_W-1:0]         lost_inc_d;
  logic                      idle_plain;

  state_e                    state_q;
  logic                      stop_q;
  logic [7:0]                duty_l_q, duty_r_q;
  logic                      cmd_valid_q;
  logic [LCNT_W-1:0]         lost_cnt_q;

  // A simultaneous valid and lost pulse is a lost update
  assign lost_ev  = enable_i & line_lost_i;
  assign valid_ev = enable_i & line_valid_i & ~line_lost_i;

  // PD correction; the first valid since enable rose has no history, so delta is 0
  always_comb begin
    err_d    = ERR_W'($signed({1'b0, centroid_x_i}) - SETPOINT);
    delta_d  = '0;
    if (have_prev_q) begin
      delta_d = $signed({err_d[ERR_W-1], err_d}) - $signed({prev_err_q[ERR_W-1], prev_err_q});
    end
    p_term_d = CORR_W'(err_d >>> KP_SHIFT);
    d_term_d = CORR_W'(delta_d >>> KD_SHIFT);
    corr_d   = p_term_d + d_term_d;
  end

  // Stage 1: capture the event and, on valid, the correction and error history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_valid_q  <= 1'b0;
      ev_lost_q   <= 1'b0;
      corr_q      <= '0;
      prev_err_q  <= '0;
      have_prev_q <= 1'b0;
    end else begin
      ev_valid_q <= valid_ev;
      ev_lost_q  <= lost_ev;
      if (!enable_i) begin
        have_prev_q <= 1'b0;
      end
      if (valid_ev) begin
        corr_q      <= corr_d;
        prev_err_q  <= err_d;
        have_prev_q <= 1'b1;
      end
    end
  end

  // Stage 2 helpers: wheel sums and the saturating lost counter
  always_comb begin
    sum_l_d    = SUM_W'(BASE_SPEED) + SUM_W'(corr_q);
    sum_r_d    = SUM_W'(BASE_SPEED) - SUM_W'(corr_q);
    lost_inc_d = (lost_cnt_q >= LCNT_W'(LOST_STOP)) ? lost_cnt_q : lost_cnt_q + 1'b1;
    idle_plain = (state_q == ST_IDLE) && !stop_q;
  end

  // Mode FSM; cmd_valid pulses on every TRACK update and on entry to a lost mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      stop_q      <= 1'b0;
      duty_l_q    <= 8'd0;
      duty_r_q    <= 8'd0;
      cmd_valid_q <= 1'b0;
      lost_cnt_q  <= '0;
    end else begin
      cmd_valid_q <= 1'b0;
      if (!enable_i) begin
        state_q    <= ST_IDLE;
        stop_q     <= 1'b0;
        duty_l_q   <= 8'd0;
        duty_r_q   <= 8'd0;
        lost_cnt_q <= '0;
      end else if (ev_valid_q) begin
        state_q     <= ST_TRACK;
        stop_q      <= 1'b0;
        duty_l_q    <= clamp_duty(sum_l_d);
        duty_r_q    <= clamp_duty(sum_r_d);
        cmd_valid_q <= 1'b1;
        lost_cnt_q  <= '0;
      end else if (ev_lost_q && !idle_plain) begin
        lost_cnt_q <= lost_inc_d;
        if (lost_inc_d >= LCNT_W'(LOST_STOP)) begin
          if (!stop_q) begin
            cmd_valid_q <= 1'b1;
          end
          state_q  <= ST_IDLE;
          stop_q   <= 1'b1;
          duty_l_q <= 8'd0;
          duty_r_q <= 8'd0;
        end else if (lost_inc_d <= LCNT_W'(LOST_HOLD)) begin
          if (state_q != ST_HOLD) begin
            cmd_valid_q <= 1'b1;
          end
          state_q <= ST_HOLD;
        end else begin
          if (state_q != ST_SEARCH) begin
            cmd_valid_q <= 1'b1;
          end
          state_q <= ST_SEARCH;
          // Spin toward the side the line was last seen on
          if (prev_err_q[ERR_W-1]) begin
            duty_l_q <= 8'd0;
            duty_r_q <= 8'(SEARCH_SPEED);
          end else begin
            duty_l_q <= 8'(SEARCH_SPEED);
            duty_r_q <= 8'd0;
          end
        end
      end
    end
  end

  assign duty_left_o  = duty_l_q;
  assign duty_right_o = duty_r_q;
  assign cmd_valid_o  = cmd_valid_q;
  assign state_o      = state_q;

  pwm_gen #(.PWM_DIV(PWM_DIV)) u_pwm_left (
    .clk   (clk),
    .rst   (rst),
    .duty_i(duty_l_q),
    .pwm_o (pwm_left_o)
  );

  pwm_gen #(.PWM_DIV(PWM_DIV)) u_pwm_right (
    .clk   (clk),
    .rst   (rst),
    .duty_i(duty_r_q),
    .pwm_o (pwm_right_o)
  );

endmodule

// File: tb/tb_steer_ctrl.sv
// Testbench for steer_ctrl.
// dut drives the steering scenarios with default parameters; dut2 runs with
// PWM_DIV=1 so full PWM periods can be measured. Expected duties, states and
// pulses come from a mode-level model of the steering rules.
module tb_steer_ctrl;

  localparam int IMG_W        = 640;
  localparam int KP_SHIFT     = 2;
  localparam int KD_SHIFT     = 3;
  localparam int BASE_SPEED   = 128;
  localparam int SEARCH_SPEED = 96;
  localparam int LOST_HOLD    = 8;
  localparam int LOST_STOP    = 64;

  // Model modes: 0 idle, 1 track, 2 hold, 3 search, 4 stop
  localparam int M_IDLE = 0, M_TRACK = 1, M_HOLD = 2, M_SEARCH = 3, M_STOP = 4;

  logic        clk;
  logic        rst, enable, lv, ll;
  logic [10:0] cx;
  logic [7:0]  dl, dr;
  logic        cv, pl, pr;
  logic [1:0]  st;

  logic        rst2, enable2, lv2, ll2;
  logic [10:0] cx2;
  logic [7:0]  dl2, dr2;
  logic        cv2, pl2, pr2;
  logic [1:0]  st2;

  int checkCount = 0;
  int errorCount = 0;
  int k2;

  int  mMode, mLost, mPrev, mDl, mDr;
  bit  mHave, mCv;

  steer_ctrl dut (
    .clk(clk), .rst(rst), .enable_i(enable), .centroid_x_i(cx),
    .line_valid_i(lv), .line_lost_i(ll),
    .duty_left_o(dl), .duty_right_o(dr), .cmd_valid_o(cv),
    .pwm_left_o(pl), .pwm_right_o(pr), .state_o(st)
  );

  steer_ctrl #(.PWM_DIV(1)) dut2 (
    .clk(clk), .rst(rst2), .enable_i(enable2), .centroid_x_i(cx2),
    .line_valid_i(lv2), .line_lost_i(ll2),
    .duty_left_o(dl2), .duty_right_o(dr2), .cmd_valid_o(cv2),
    .pwm_left_o(pl2), .pwm_right_o(pr2), .state_o(st2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Posedges since dut2 left reset; with PWM_DIV=1 this is its PWM phase
  always @(posedge clk or posedge rst2) begin
    if (rst2) k2 <= 0;
    else      k2 <= k2 + 1;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checkCount++;
    assert (obs === exp) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int floorShift(input int a, input int sh);
    int d;
    d = 1 << sh;
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic int clampDuty(input int v);
    if (v < 0)   return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic int expState();
    return (mMode == M_STOP) ? 0 : mMode;
  endfunction

  task automatic modelReset();
    mMode = M_IDLE; mLost = 0; mPrev = 0; mHave = 0; mDl = 0; mDr = 0; mCv = 0;
  endtask

  task automatic modelEnableOff();
    mMode = M_IDLE; mLost = 0; mHave = 0; mDl = 0; mDr = 0; mCv = 0;
  endtask

  task automatic modelEvent(input bit v, input bit l, input int x);
    int err, delta, corr, newMode;
    mCv = 0;
    if (l) begin
      if (mMode == M_IDLE) return;
      if (mLost < LOST_STOP) mLost = mLost + 1;
      if (mLost >= LOST_STOP)      newMode = M_STOP;
      else if (mLost <= LOST_HOLD) newMode = M_HOLD;
      else                         newMode = M_SEARCH;
      if (newMode != mMode) mCv = 1;
      mMode = newMode;
      if (mMode == M_STOP) begin
        mDl = 0; mDr = 0;
      end else if (mMode == M_SEARCH) begin
        mDl = (mPrev >= 0) ? SEARCH_SPEED : 0;
        mDr = (mPrev >= 0) ? 0 : SEARCH_SPEED;
      end
    end else if (v) begin
      err   = x - IMG_W / 2;
      delta = mHave ? err - mPrev : 0;
      corr  = floorShift(err, KP_SHIFT) + floorShift(delta, KD_SHIFT);
      mDl   = clampDuty(BASE_SPEED + corr);
      mDr   = clampDuty(BASE_SPEED - corr);
      mPrev = err; mHave = 1; mLost = 0; mMode = M_TRACK; mCv = 1;
    end
  endtask

  // Starts and ends on a negedge; checks the outputs two cycles after the pulse
  task automatic applyStimulus(input bit useDut2, input bit v, input bit l, input int x, input string tag);
    if (!useDut2) begin lv = v; ll = l; cx = 11'(x); end
    else          begin lv2 = v; ll2 = l; cx2 = 11'(x); end
    @(negedge clk);
    lv = 0; ll = 0; lv2 = 0; ll2 = 0;
    checkOutput({tag, "_cmd_early"}, useDut2 ? int'(cv2) : int'(cv), 0);
    @(negedge clk);
    modelEvent(v, l, x);
    checkOutput({tag, "_duty_left"},  useDut2 ? int'(dl2) : int'(dl), mDl);
    checkOutput({tag, "_duty_right"}, useDut2 ? int'(dr2) : int'(dr), mDr);
    checkOutput({tag, "_state"},      useDut2 ? int'(st2) : int'(st), expState());
    checkOutput({tag, "_cmd_valid"},  useDut2 ? int'(cv2) : int'(cv), int'(mCv));
  endtask

  task automatic dropEnable(input string tag);
    enable = 0;
    @(negedge clk);
    modelEnableOff();
    checkOutput({tag, "_state"},      int'(st), 0);
    checkOutput({tag, "_duty_left"},  int'(dl), 0);
    checkOutput({tag, "_duty_right"}, int'(dr), 0);
    enable = 1;
    @(negedge clk);
  endtask

  task automatic waitPhase(input int phase);
    int guard;
    @(negedge clk);
    guard = 1;
    while ((k2 % 256) != phase && guard < 700) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("pwm_phase_reached", k2 % 256, phase);
  endtask

  task automatic countHighs(input int cycles, output int hl, output int hr);
    hl = 0; hr = 0;
    for (int i = 0; i < cycles; i++) begin
      hl += int'(pl2);
      hr += int'(pr2);
      @(negedge clk);
    end
  endtask

  initial begin
    int hl, hr, oldL, oldR, startPhase, expL, expR;
    rst = 1; enable = 0; lv = 0; ll = 0; cx = '0;
    rst2 = 1; enable2 = 0; lv2 = 0; ll2 = 0; cx2 = '0;
    modelReset();
    repeat (3) @(negedge clk);

    checkOutput("reset_duty_left",  int'(dl), 0);
    checkOutput("reset_duty_right", int'(dr), 0);
    checkOutput("reset_cmd_valid",  int'(cv), 0);
    checkOutput("reset_state",      int'(st), 0);
    checkOutput("reset_pwm_left",   int'(pl), 0);
    checkOutput("reset_pwm_right",  int'(pr), 0);

    rst = 0; enable = 1;
    @(negedge clk);

    $display("[TB] scenario 1-3: tracking and clamping");
    applyStimulus(0, 1, 0, 320, "s1");
    checkOutput("s1_left_128", int'(dl), 128);
    checkOutput("s1_right_128", int'(dr), 128);
    applyStimulus(0, 1, 0, 400, "s2");
    checkOutput("s2_left_158", int'(dl), 158);
    checkOutput("s2_right_98", int'(dr), 98);
    applyStimulus(0, 1, 0, 320, "s3_pre");
    applyStimulus(0, 1, 0, 1200, "s3");
    checkOutput("s3_left_255", int'(dl), 255);
    checkOutput("s3_right_0", int'(dr), 0);

    $display("[TB] scenario 4: lost line sequence");
    applyStimulus(0, 1, 0, 320, "s4_pre");
    applyStimulus(0, 1, 0, 400, "s4_err80");
    for (int i = 1; i <= 66; i++) begin
      applyStimulus(0, 0, 1, 0, "s4_lost");
      if (i == 1 || i == 8) begin
        checkOutput("s4_hold_state", int'(st), 2);
        checkOutput("s4_hold_left", int'(dl), 158);
        checkOutput("s4_hold_right", int'(dr), 98);
      end else if (i == 9) begin
        checkOutput("s4_search_state", int'(st), 3);
        checkOutput("s4_search_left", int'(dl), 96);
        checkOutput("s4_search_right", int'(dr), 0);
      end else if (i == 64) begin
        checkOutput("s4_stop_state", int'(st), 0);
        checkOutput("s4_stop_left", int'(dl), 0);
        checkOutput("s4_stop_right", int'(dr), 0);
      end
    end
    applyStimulus(0, 1, 0, 400, "s4_recover");
    checkOutput("s4_recover_state", int'(st), 1);

    $display("[TB] scenario 6a: enable dropped in SEARCH");
    for (int i = 0; i < 9; i++) applyStimulus(0, 0, 1, 0, "s6_lost");
    checkOutput("s6_in_search", int'(st), 3);
    dropEnable("s6_disable");
    applyStimulus(0, 0, 1, 0, "s6_idle_lost");
    applyStimulus(0, 1, 1, 500, "s6_idle_both");
    applyStimulus(0, 1, 0, 500, "s6_first_valid");

    $display("[TB] random events");
    for (int n = 0; n < 150; n++) begin
      int kind, runLen;
      kind = $urandom_range(0, 19);
      if (kind == 0) begin
        dropEnable("rnd_disable");
      end else if (kind < 10) begin
        applyStimulus(0, 1, 0, $urandom_range(0, 2047), "rnd_valid");
      end else if (kind < 12) begin
        applyStimulus(0, 1, 1, $urandom_range(0, 2047), "rnd_both");
      end else begin
        runLen = (kind == 19) ? $urandom_range(50, 70) : $urandom_range(1, 12);
        for (int j = 0; j < runLen; j++) applyStimulus(0, 0, 1, 0, "rnd_lost");
      end
    end

    $display("[TB] scenario 6b: reset while tracking");
    applyStimulus(0, 1, 0, 450, "s6_track");
    #2 rst = 1;
    #1;
    checkOutput("s6_rst_duty_left",  int'(dl), 0);
    checkOutput("s6_rst_duty_right", int'(dr), 0);
    checkOutput("s6_rst_cmd_valid",  int'(cv), 0);
    checkOutput("s6_rst_state",      int'(st), 0);
    checkOutput("s6_rst_pwm_left",   int'(pl), 0);
    checkOutput("s6_rst_pwm_right",  int'(pr), 0);
    @(negedge clk);
    rst = 0;

    $display("[TB] scenario 5: PWM with PWM_DIV=1");
    modelReset();
    rst2 = 0; enable2 = 1;
    @(negedge clk);
    applyStimulus(1, 1, 0, 1200, "p_full");
    waitPhase(0);
    countHighs(256, hl, hr);
    checkOutput("pwm_255_left_highs", hl, 255);
    checkOutput("pwm_0_right_highs", hr, 0);

    applyStimulus(1, 1, 0, 576, "p_mid");
    waitPhase(0);
    countHighs(256, hl, hr);
    checkOutput("pwm_left_highs", hl, mDl);
    checkOutput("pwm_right_highs", hr, mDr);

    oldL = mDl; oldR = mDr;
    waitPhase(100);
    applyStimulus(1, 1, 0, 320, "p_change");
    startPhase = k2 % 256;
    expL = 0; expR = 0;
    for (int c = startPhase; c < 256; c++) begin
      if (c < oldL) expL++;
      if (c < oldR) expR++;
    end
    countHighs(256 - startPhase, hl, hr);
    checkOutput("pwm_change_held_left", hl, expL);
    checkOutput("pwm_change_held_right", hr, expR);
    countHighs(256, hl, hr);
    checkOutput("pwm_new_left_highs", hl, mDl);
    checkOutput("pwm_new_right_highs", hr, mDr);

    waitPhase(5);
    checkOutput("pwm_high_before_rst", int'(pr2), (5 < mDr) ? 1 : 0);
    #2 rst2 = 1;
    #1;
    checkOutput("pwm_rst_left", int'(pl2), 0);
    checkOutput("pwm_rst_right", int'(pr2), 0);
    checkOutput("pwm_rst_duty_right", int'(dr2), 0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/steer_ctrl.md
STEER_CTRL -- requirements
Module: steer_ctrl

Interface
REQ-001 Parameter IMG_W, default 640, image width in pixels; the setpoint is IMG_W/2.
REQ-002 Parameter KP_SHIFT, default 2, proportional gain expressed as an arithmetic right shift of the error.
REQ-003 Parameter KD_SHIFT, default 3, derivative gain expressed as an arithmetic right shift of the delta.
REQ-004 Parameter BASE_SPEED, default 128, nominal duty in 0..255.
REQ-005 Parameter SEARCH_SPEED, default 96, duty of the driven wheel while searching.
REQ-006 Parameter LOST_HOLD, default 8; parameter LOST_STOP, default 64; both are consecutive-lost-update thresholds.
REQ-007 Parameter PWM_DIV, default 4, number of clk cycles per PWM count.
REQ-008 clk  in  1  system clock.
REQ-009 rst  in  1  asynchronous, active-high reset.
REQ-010 enable  in  1  level input; 0 forces IDLE with motors off.
REQ-011 centroid_x  in  11  line centroid, unsigned; sampled only when line_valid=1.
REQ-012 line_valid  in  1  one-cycle pulse marking a new centroid.
REQ-013 line_lost  in  1  one-cycle pulse marking an update with no line found.
REQ-014 duty_left, duty_right  out  8  registered duty commands.
REQ-015 cmd_valid  out  1  one-cycle pulse in the cycle the duties change source (TRACK update, state entry).
REQ-016 pwm_left, pwm_right  out  1  motor PWM outputs.
REQ-017 state  out  2  current FSM state: IDLE=0, TRACK=1, HOLD=2, SEARCH=3; STOP is encoded via the stop_flag rule in REQ-028.

Function
REQ-018 An update event is line_valid=1 or line_lost=1; if both are high in the same cycle, the event SHALL be treated as lost.
REQ-019 error SHALL be the 12-bit signed value centroid_x - IMG_W/2; delta SHALL be error - prev_error, 13-bit signed.
REQ-020 prev_error SHALL update only on valid events; the first valid after IDLE SHALL force delta to 0.
REQ-021 corr SHALL be (error >>> KP_SHIFT) + (delta >>> KD_SHIFT), computed at full width with no intermediate truncation.
REQ-022 duty_left SHALL be clamp(BASE_SPEED + corr, 0, 255); duty_right SHALL be clamp(BASE_SPEED - corr, 0, 255).
REQ-023 In TRACK, duties and cmd_valid SHALL update exactly 2 clk cycles after the line_valid cycle.
REQ-024 lost_cnt SHALL count consecutive lost events, saturating at LOST_STOP, and SHALL clear on any valid event.
REQ-025 IDLE: duties are 0; a valid event with enable=1 moves to TRACK; lost events are ignored.
REQ-026 TRACK, HOLD, SEARCH and STOP: a valid event moves to TRACK (PD path).
REQ-027 Lost event, with the updated lost_cnt: lost_cnt <= LOST_HOLD gives HOLD, which keeps the last duties; lost_cnt between LOST_HOLD and LOST_STOP (exclusive) gives SEARCH.
REQ-028 Lost event reaching lost_cnt >= LOST_STOP gives STOP: duties 0, state output 0, and an internal stop_flag distinguishes STOP from IDLE.
REQ-029 SEARCH duties: if last error >= 0, left = SEARCH_SPEED and right = 0; otherwise the mirror assignment.
REQ-030 enable=0 in any state SHALL move to IDLE on the next cycle, with duties 0 and lost_cnt cleared.
REQ-031 The PWM counter SHALL be 8 bits, free-running, and advance once per PWM_DIV clk cycles.
REQ-032 pwm_x SHALL be (cnt < shadow_duty_x); the shadow SHALL reload from duty_x only when cnt wraps 255->0.
REQ-033 Duty 0 SHALL give constant low; duty 255 SHALL give high for 255 of 256 counts.

Reset
REQ-034 rst SHALL immediately set: state IDLE, stop_flag 0, duties 0, shadows 0, pwm outputs 0, cmd_valid 0, prev_error 0, lost_cnt 0, PWM counter and prescaler 0.
REQ-035 A reset asserted mid-period SHALL drive the pwm outputs low asynchronously.

Structure
REQ-036 Package steer_pkg SHALL hold the state enum, the DUTY_MAX=255 constant and the error/correction widths.
REQ-037 Sub-module pwm_gen (prescaler, counter, shadow, compare) SHALL be instantiated once per wheel, with the counters sharing reset timing.

Verification
All scenarios use default parameters unless stated.
REQ-038 Scenario 1: enable=1, valid with centroid 320 -> TRACK, duties 128/128, cmd_valid 2 cycles after the valid pulse.
REQ-039 Scenario 2: then valid with centroid 400 -> error 80, delta 80, corr 30, duties 158/98.
REQ-040 Scenario 3: from prev_error 0, valid with centroid 1200 -> corr 330, duties 255/0 (clamped).
REQ-041 Scenario 4: after error +80, lost pulses -> pulses 1-8 HOLD at 158/98, pulse 9 SEARCH at 96/0, pulse 64 STOP at 0/0, next valid returns to TRACK.
REQ-042 Scenario 5: PWM_DIV=1, duty 64 -> pwm high for exactly 64 of 256 cycles; a duty change mid-period takes effect only at the next wrap.
REQ-043 Scenario 6: enable dropped in SEARCH -> IDLE with 0/0 on the next cycle; rst in TRACK -> all outputs 0 immediately.
